ym_phase_sched: RTL and testbench

YM_PHASE_SCHED -- requirements
Module: ym_phase_sched

---
 rtl/ym_phase_sched.sv | 128 ++++++++++++
 tb/tb_ym_phase_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ym_phase_sched.sv
// Two-phase clock scheduler: divides MCLK into slot periods of L cycles,
// emits non-overlapping c1/c2 enables, and tracks slot/frame position.
module ym_phase_sched #(
  parameter int SLOTS = 24
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] div_sel,
  input  logic       sync,
  output logic       c1,
  output logic       c2,
  output logic [4:0] slot,
  output logic       frame,
  output logic       running,
  output logic [1:0] div_cur
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

  logic [0:0] state_r, state_s;
  logic [3:0] pcnt_r, pcnt_s;
  logic [4:0] slot_r, slot_s;
  logic [1:0] div_r, div_s;
  logic       sync_flag_r, sync_flag_s;
  logic       c1_r, c2_r, frame_r;
  logic       c1_s, c2_s, frame_s;
  logic [3:0] len_cur_s, len_nxt_s, half_nxt_s;
  logic       wrap_s, run_nxt_s;
  logic [4:0] slot_inc_s;

  function automatic logic [3:0] period_len(input logic [1:0] d);
    case (d)
      2'd1:    period_len = 4'd6;
      2'd2:    period_len = 4'd4;
      default: period_len = 4'd12;
    endcase
  endfunction

  // Period length, wrap detection and slot increment for the current cycle
  always_comb begin
    len_cur_s  = period_len(div_r);
    wrap_s     = (state_r == ST_RUN) && (pcnt_r == (len_cur_s - 4'd1));
    slot_inc_s = (slot_r == SLOT_LAST) ? 5'd0 : (slot_r + 5'd1);
  end

  // Next-state logic: en, div_sel and a pending sync act only at IDLE or the wrap edge
  always_comb begin
    state_s     = state_r;
    pcnt_s      = pcnt_r;
    slot_s      = slot_r;
    div_s       = div_r;
    sync_flag_s = sync_flag_r;
    case (state_r)
      ST_IDLE: begin
        sync_flag_s = sync_flag_r | sync;
        if (en) begin
          state_s = ST_RUN;
          pcnt_s  = 4'd0;
          div_s   = div_sel;
        end else begin
          state_s = ST_IDLE;
          pcnt_s  = 4'd0;
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          // A sync arriving on the wrap edge itself still realigns this wrap
          slot_s      = (sync_flag_r | sync) ? 5'd0 : slot_inc_s;
          sync_flag_s = 1'b0;
          div_s       = div_sel;
          pcnt_s      = 4'd0;
          state_s     = en ? ST_RUN : ST_IDLE;
        end else begin
          pcnt_s      = pcnt_r + 4'd1;
          sync_flag_s = sync_flag_r | sync;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pcnt_s  = 4'd0;
      end
    endcase
  end

  // Output decode from next-cycle values so registered outputs match the pcnt register
  always_comb begin
    run_nxt_s  = (state_s == ST_RUN);
    len_nxt_s  = period_len(div_s);
    half_nxt_s = len_nxt_s >> 1;
    c1_s       = run_nxt_s && ((pcnt_s + 4'd2) <= half_nxt_s);
    c2_s       = run_nxt_s && (pcnt_s >= half_nxt_s) && ((pcnt_s + 4'd2) <= len_nxt_s);
    frame_s    = run_nxt_s && (pcnt_s == (len_nxt_s - 4'd1)) && (slot_s == SLOT_LAST);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      pcnt_r      <= 4'd0;
      slot_r      <= 5'd0;
      div_r       <= 2'd0;
      sync_flag_r <= 1'b0;
      c1_r        <= 1'b0;
      c2_r        <= 1'b0;
      frame_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pcnt_r      <= pcnt_s;
      slot_r      <= slot_s;
      div_r       <= div_s;
      sync_flag_r <= sync_flag_s;
      c1_r        <= c1_s;
      c2_r        <= c2_s;
      frame_r     <= frame_s;
    end
  end

  assign c1      = c1_r;
  assign c2      = c2_r;
  assign slot    = slot_r;
  assign frame   = frame_r;
  assign running = (state_r == ST_RUN);
  assign div_cur = div_r;

endmodule

// File: tb/tb_ym_phase_sched.sv
// Self-checking bench for ym_phase_sched: vector table, directed corner
// sequences and randomized stimulus against a period/slot reference model.
module tb_ym_phase_sched;
  localparam int SLOTS = 24;

  logic       MCLK = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] div_sel;
  logic       sync;
  logic       c1, c2, frame, running;
  logic [4:0] slot;
  logic [1:0] div_cur;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_run;
  int m_p, m_slot, m_div;
  bit m_sync;

  typedef struct {
    bit       en;
    bit [1:0] div;
    bit       sync;
    bit       c1;
    bit       c2;
    int       slot;
    bit       run;
    int       dcur;
  } vec_t;
  vec_t vecs[13];

  ym_phase_sched #(.SLOTS(SLOTS)) dut (
    .MCLK(MCLK), .reset(reset), .en(en), .div_sel(div_sel), .sync(sync),
    .c1(c1), .c2(c2), .slot(slot), .frame(frame), .running(running), .div_cur(div_cur)
  );

  always #5 MCLK = ~MCLK;

  function automatic int len_of(input int d);
    return (d == 1) ? 6 : ((d == 2) ? 4 : 12);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int len;
    len = len_of(m_div);
    if (!m_run) begin
      m_sync = m_sync | sync;
      if (en) begin
        m_run = 1; m_p = 0; m_div = div_sel;
      end
    end else if (m_p == len - 1) begin
      m_slot = (m_sync || sync) ? 0 : (m_slot + 1) % SLOTS;
      m_sync = 0;
      m_div  = div_sel;
      m_p    = 0;
      m_run  = en;
    end else begin
      m_p++;
      m_sync = m_sync | sync;
    end
  endtask

  task automatic check_model();
    int len;
    len = len_of(m_div);
    check("model_c1", c1, int'(m_run && (m_p < len / 2 - 1)));
    check("model_c2", c2, int'(m_run && (m_p >= len / 2) && (m_p < len - 1)));
    check("model_slot", slot, m_slot);
    check("model_frame", frame, int'(m_run && (m_p == len - 1) && (m_slot == SLOTS - 1)));
    check("model_running", running, int'(m_run));
    check("model_div_cur", div_cur, m_run || m_div != 0 ? m_div : 0);
    check("no_overlap", int'(c1 & c2), 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge MCLK);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    en = 1'b0; sync = 1'b0; div_sel = 2'd0;
    reset = 1'b0;
    m_run = 0; m_p = 0; m_slot = 0; m_div = 0; m_sync = 0;
    #1;
    check("reset_c1", c1, 0);
    check("reset_c2", c2, 0);
    check("reset_slot", slot, 0);
    check("reset_running", running, 0);
    check("reset_frame", frame, 0);
    check("reset_div_cur", div_cur, 0);
    @(negedge MCLK);
    reset = 1'b1;
  endtask

  initial begin
    int frames, frame_edge;
    reset = 1'b1; en = 1'b0; sync = 1'b0; div_sel = 2'd0;

    // Table: fast divider, mid-period en drop, divider change, sync realign
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 0, 1'b1, 2};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 0, 1'b1, 2};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1};
    vecs[7]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 0, 1'b1, 2};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; div_sel = vecs[i].div; sync = vecs[i].sync;
      tick();
      check($sformatf("vec%0d_c1", i), c1, vecs[i].c1);
      check($sformatf("vec%0d_c2", i), c2, vecs[i].c2);
      check($sformatf("vec%0d_slot", i), slot, vecs[i].slot);
      check($sformatf("vec%0d_running", i), running, vecs[i].run);
      check($sformatf("vec%0d_div_cur", i), div_cur, vecs[i].dcur);
    end
    sync = 1'b0;

    // L=12 waveform: c1 5 high, 1 gap, c2 5 high, 1 gap; slot 1 after 12 cycles
    do_reset();
    en = 1'b1; div_sel = 2'd0;
    for (int k = 0; k < 13; k++) begin
      tick();
      check("l12_c1", c1, int'((k % 12) < 5));
      check("l12_c2", c2, int'((k % 12) >= 6 && (k % 12) <= 10));
      check("l12_slot", slot, (k == 12) ? 1 : 0);
    end

    // L=4 full frame: single frame pulse at MCLK 96, slot back to 0
    do_reset();
    en = 1'b1; div_sel = 2'd2;
    frames = 0; frame_edge = -1;
    for (int e = 1; e <= 97; e++) begin
      tick();
      check("l4_c1", c1, int'(((e - 1) % 4) == 0));
      check("l4_c2", c2, int'(((e - 1) % 4) == 2));
      if (frame) begin frames++; frame_edge = e; end
    end
    check("frame_count", frames, 1);
    check("frame_edge", frame_edge, 96);
    check("frame_slot_wrap", slot, 0);

    // Divider change mid-period in slot 5 only takes effect at the wrap
    do_reset();
    en = 1'b1; div_sel = 2'd0;
    for (int e = 1; e <= 64; e++) tick();
    div_sel = 2'd1;
    for (int e = 65; e <= 79; e++) begin
      tick();
      check("div_slot", slot, (e <= 72) ? 5 : ((e <= 78) ? 6 : 7));
      check("div_cur_edge", div_cur, (e <= 72) ? 0 : 1);
    end

    // Sync pulse in slot 10 realigns to slot 0 at the wrap, no frame
    do_reset();
    en = 1'b1; div_sel = 2'd2;
    frames = 0;
    for (int e = 1; e <= 42; e++) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    tick();
    check("sync_slot_hold", slot, 10);
    tick();
    check("sync_slot_zero", slot, 0);
    if (frame) frames++;
    check("sync_no_frame", frames, 0);

    // en dropped at pcnt 2: period completes, idle with slot advanced, resume
    do_reset();
    en = 1'b1; div_sel = 2'd2;
    for (int e = 1; e <= 3; e++) tick();
    en = 1'b0;
    tick();
    check("endrop_running_mid", running, 1);
    tick();
    check("endrop_running_wrap", running, 0);
    check("endrop_slot", slot, 1);
    tick();
    check("endrop_idle_c1", c1, 0);
    en = 1'b1;
    tick();
    check("resume_c1", c1, 1);
    check("resume_running", running, 1);

    // Async reset at pcnt 7 of slot 1 clears outputs without a clock edge
    do_reset();
    en = 1'b1; div_sel = 2'd0;
    for (int e = 1; e <= 20; e++) tick();
    check("pre_reset_c2", c2, 1);
    check("pre_reset_slot", slot, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_c2", c2, 0);
    check("async_slot", slot, 0);
    check("async_running", running, 0);
    m_run = 0; m_p = 0; m_slot = 0; m_div = 0; m_sync = 0;
    @(negedge MCLK);
    reset = 1'b1;
    en = 1'b0;
    tick();
    check("post_reset_idle", running, 0);

    // Randomized run against the reference model with occasional async resets
    for (int n = 0; n < 4000; n++) begin
      en      = ($urandom % 16) != 0;
      div_sel = 2'($urandom % 4);
      sync    = ($urandom % 32) == 0;
      if (($urandom % 500) == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
